// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - md_op_e     : 4-bit MD operation encodings driven on the mod input
//   - md_state_e  : sequencer FSM states
//   - default latencies and small op-classification helpers
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MdNop   = 4'd0,
    MdMult  = 4'd1,
    MdMultu = 4'd2,
    MdDiv   = 4'd3,
    MdDivu  = 4'd4,
    MdMadd  = 4'd5,
    MdMaddu = 4'd6,
    MdMsub  = 4'd7,
    MdMsubu = 4'd8,
    MdMthi  = 4'd9,
    MdMtlo  = 4'd10
  } md_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } md_state_e;

  localparam int unsigned MduMultCyclesDef = 5;
  localparam int unsigned MduDivCyclesDef  = 10;

  // Divide ops use the longer latency.
  function automatic logic op_is_div(input logic [3:0] op);
    return (op == MdDiv) || (op == MdDivu);
  endfunction

  // Ops that occupy the unit for a multi-cycle latency before committing.
  function automatic logic op_is_long(input logic [3:0] op);
    logic r;
    case (op)
      MdMult, MdMultu, MdDiv, MdDivu,
      MdMadd, MdMaddu, MdMsub, MdMsubu: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

  // Direct HI/LO writes that complete at the start edge.
  function automatic logic op_is_move(input logic [3:0] op);
    return (op == MdMthi) || (op == MdMtlo);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MD datapath. Produces the full next HI/LO value for one op.
// Ports:
//   mod            - operation encoding (md_op_e)
//   d1, d2         - rs / rt operands
//   HI, LO         - current architectural HI/LO (accumulate and move ops)
//   res_hi, res_lo - resulting HI/LO
//   res_we         - result is to be written (0 for NOP and divide-by-zero)
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  mod,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [31:0] HI,
  input  logic [31:0] LO,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_we
);

  logic signed [63:0] sx1, sx2;
  logic [63:0]        prod_s, prod_u, acc;

  logic [31:0] mag1, mag2, mag2_safe, d2_safe;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        div_zero;

  assign sx1    = {{32{d1[31]}}, d1};
  assign sx2    = {{32{d2[31]}}, d2};
  assign prod_s = sx1 * sx2;
  assign prod_u = {32'd0, d1} * {32'd0, d2};
  assign acc    = {HI, LO};

  // Signed divide through magnitudes so the 0x80000000 / -1 corner is exact:
  // |0x80000000| is 0x80000000 as an unsigned value, the quotient sign is
  // positive, and the result wraps back to 0x80000000 with remainder 0.
  assign div_zero  = (d2 == 32'd0);
  assign mag1      = d1[31] ? (~d1 + 32'd1) : d1;
  assign mag2      = d2[31] ? (~d2 + 32'd1) : d2;
  // Dummy divisor keeps the dividers free of X when d2 is zero; result unused.
  assign mag2_safe = div_zero ? 32'd1 : mag2;
  assign d2_safe   = div_zero ? 32'd1 : d2;
  assign q_mag     = mag1 / mag2_safe;
  assign r_mag     = mag1 % mag2_safe;
  assign q_s       = (d1[31] ^ d2[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s       = d1[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u       = d1 / d2_safe;
  assign r_u       = d1 % d2_safe;

  always_comb begin
    res_hi = HI;
    res_lo = LO;
    res_we = 1'b0;
    case (mod)
      MdMult: begin
        {res_hi, res_lo} = prod_s;
        res_we           = 1'b1;
      end
      MdMultu: begin
        {res_hi, res_lo} = prod_u;
        res_we           = 1'b1;
      end
      MdMadd: begin
        {res_hi, res_lo} = acc + prod_s;
        res_we           = 1'b1;
      end
      MdMaddu: begin
        {res_hi, res_lo} = acc + prod_u;
        res_we           = 1'b1;
      end
      MdMsub: begin
        {res_hi, res_lo} = acc - prod_s;
        res_we           = 1'b1;
      end
      MdMsubu: begin
        {res_hi, res_lo} = acc - prod_u;
        res_we           = 1'b1;
      end
      MdDiv: begin
        res_hi = r_s;
        res_lo = q_s;
        res_we = ~div_zero;
      end
      MdDivu: begin
        res_hi = r_u;
        res_lo = q_u;
        res_we = ~div_zero;
      end
      MdMthi: begin
        res_hi = d1;
        res_we = 1'b1;
      end
      MdMtlo: begin
        res_lo = d1;
        res_we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage. A start pulse in idle computes
// the result immediately, parks it in pending registers, holds busy for a
// fixed latency and then commits it to HI/LO. MTHI/MTLO write at the start
// edge without occupying the unit.
// Ports:
//   clk, rst       - clock (rising edge), asynchronous active-low reset
//   start, mod     - op valid pulse and op encoding
//   d1, d2         - forwarded rs / rt operands
//   d_is_md        - D-stage instruction uses the MD unit
//   busy           - operation in flight
//   stall_md       - D-stage stall request, d_is_md & (busy | start)
//   HI, LO         - architectural HI/LO
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MduMultCyclesDef,
  parameter int unsigned DIV_CYCLES  = MduDivCyclesDef
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  mod,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     pend_hi_q, pend_hi_d;
  logic [31:0]     pend_lo_q, pend_lo_d;
  logic            pend_we_q, pend_we_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic [31:0] res_hi, res_lo;
  logic        res_we;

  mdu_calc u_calc (
    .mod    (mod),
    .d1     (d1),
    .d2     (d2),
    .HI     (hi_q),
    .LO     (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .res_we (res_we)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op_is_long(mod)) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            // Divide-by-zero still runs the full latency but commits nothing.
            pend_we_d = res_we;
            cnt_d     = op_is_div(mod) ? DivCnt : MultCnt;
            state_d   = StRun;
          end else if (op_is_move(mod)) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      StRun: begin
        // A start arriving here is a protocol error and is deliberately ignored.
        if (cnt_q == CntOne) begin
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign stall_md = d_is_md & (busy | start);
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule
